// File: rtl/vec_cache_rd_data_master_xbar_if.sv
// Payload types and the bundled handshake interface for the vector cache
// read-data master crossbar. The xbar sits on the "slave" modport. The
// response channels and the upstream masters sit on the "master" modport.

package vec_cache_rd_data_master_xbar_pkg;

    // master_id is wide enough for up to 16 master ports.
    localparam int MASTER_ID_W = 4;

    typedef struct packed {
        logic [MASTER_ID_W-1:0] master_id;
        logic [3:0]             tag;
    } txn_id_t;

    typedef struct packed {
        txn_id_t     txn_id;
        logic [31:0] data;
    } us_data_pld_t;

endpackage

interface vec_cache_rd_data_master_xbar_if
    import vec_cache_rd_data_master_xbar_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 16
);
    logic [M-1:0] in_vld;
    logic [M-1:0] in_rdy;
    us_data_pld_t in_pld [M];
    logic [N-1:0] out_vld;
    logic [N-1:0] out_rdy;
    us_data_pld_t out_pld [N];
    logic         err_bad_id;

    modport slave (
        input  in_vld, in_pld, out_rdy,
        output in_rdy, out_vld, out_pld, err_bad_id
    );

    modport master (
        output in_vld, in_pld, out_rdy,
        input  in_rdy, out_vld, out_pld, err_bad_id
    );
endinterface

// File: rtl/vec_cache_rd_data_master_xbar.sv
// Registered read-data crossbar. It routes M response beats per cycle to N
// master ports by txn_id.master_id. Each output has a round-robin arbiter
// and a D-deep FIFO. Beats with an out-of-range id are swallowed and flagged.

module vec_cache_rd_data_master_xbar
    import vec_cache_rd_data_master_xbar_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 16,
    parameter int D = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    vec_cache_rd_data_master_xbar_if.slave   bus
);

    localparam int RRW = (M > 1) ? $clog2(M) : 1;
    localparam int DW  = (D > 1) ? $clog2(D) : 1;
    localparam int CW  = $clog2(D + 1);

    logic [RRW-1:0] rr      [N];
    logic [DW-1:0]  wptr    [N];
    logic [DW-1:0]  rptr    [N];
    logic [CW-1:0]  cnt     [N];
    us_data_pld_t   mem     [N][D];
    logic           err_q;

    logic [N-1:0]   gnt_vld;
    logic [RRW-1:0] gnt_idx [N];
    logic [N-1:0]   push;
    logic [N-1:0]   pop;
    logic [M-1:0]   bad_id;
    logic [M-1:0]   in_rdy_c;

    // Per-output round-robin search from rr[j]. A grant is issued only
    // when the FIFO had room at the start of the cycle.
    always_comb begin
        int cand_i;
        logic [RRW-1:0] cand;
        cand_i = 0;
        cand   = '0;
        for (int j = 0; j < N; j++) begin
            gnt_vld[j] = 1'b0;
            gnt_idx[j] = '0;
            if (cnt[j] < CW'(D)) begin
                for (int k = 0; k < M; k++) begin
                    cand_i = int'(rr[j]) + k;
                    if (cand_i >= M) begin
                        cand_i = cand_i - M;
                    end
                    cand = RRW'(cand_i);
                    if (!gnt_vld[j] && bus.in_vld[cand] &&
                        (int'(bus.in_pld[cand].txn_id.master_id) == j)) begin
                        gnt_vld[j] = 1'b1;
                        gnt_idx[j] = cand;
                    end
                end
            end
        end
    end

    // Input ready is the grant from the addressed output. Bad ids are
    // always accepted so that they drain. Everything is held off in reset.
    always_comb begin
        in_rdy_c = '0;
        bad_id   = '0;
        for (int i = 0; i < M; i++) begin
            if (int'(bus.in_pld[i].txn_id.master_id) >= N) begin
                bad_id[i]   = 1'b1;
                in_rdy_c[i] = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (gnt_vld[j]) begin
                in_rdy_c[gnt_idx[j]] = 1'b1;
            end
        end
        if (rst) begin
            in_rdy_c = '0;
        end
    end

    // A push follows the grant. A pop needs a non-empty FIFO, so ready on an
    // empty output does nothing.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            push[j] = gnt_vld[j];
            pop[j]  = bus.out_rdy[j] && (cnt[j] != '0);
        end
    end

    // FIFO bookkeeping, arbiter pointers and the sticky bad-id flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                cnt[j]  <= '0;
                wptr[j] <= '0;
                rptr[j] <= '0;
                rr[j]   <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (push[j]) begin
                    wptr[j] <= (wptr[j] == DW'(D - 1)) ? '0 : wptr[j] + 1'b1;
                    rr[j]   <= (int'(gnt_idx[j]) == M - 1) ? '0 : gnt_idx[j] + 1'b1;
                end
                if (pop[j]) begin
                    rptr[j] <= (rptr[j] == DW'(D - 1)) ? '0 : rptr[j] + 1'b1;
                end
                if (push[j] && !pop[j]) begin
                    cnt[j] <= cnt[j] + 1'b1;
                end else if (pop[j] && !push[j]) begin
                    cnt[j] <= cnt[j] - 1'b1;
                end
            end
            if (|(bus.in_vld & bad_id)) begin
                err_q <= 1'b1;
            end
        end
    end

    // FIFO storage carries no reset, because occupancy masks any stale
    // entries.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (push[j]) begin
                mem[j][wptr[j]] <= bus.in_pld[gnt_idx[j]];
            end
        end
    end

    // FIFO heads drive the outputs. The payload is zero while a FIFO is empty.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            bus.out_vld[j] = (cnt[j] != '0);
            bus.out_pld[j] = (cnt[j] != '0) ? mem[j][rptr[j]] : '0;
        end
    end

    assign bus.in_rdy     = in_rdy_c;
    assign bus.err_bad_id = err_q;

endmodule
